// File: rtl/regfile_hilo_if.sv
// Writeback/decode bundle for the GPR + HI/LO register file.
// master = pipeline side driving writes and read requests, slave = register file.
interface regfile_hilo_if;
  logic        rf_wren_i;
  logic [4:0]  rf_waddr_i;
  logic [31:0] rf_wdata_i;
  logic        whien_i;
  logic        wloen_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        rd1_en_i;
  logic [4:0]  rd1_addr_i;
  logic [31:0] rd1_data_o;
  logic        rd2_en_i;
  logic [4:0]  rd2_addr_i;
  logic [31:0] rd2_data_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output rf_wren_i, rf_waddr_i, rf_wdata_i,
    output whien_i, wloen_i, hi_i, lo_i,
    output rd1_en_i, rd1_addr_i, rd2_en_i, rd2_addr_i,
    input  rd1_data_o, rd2_data_o, hi_o, lo_o
  );

  modport slave (
    input  rf_wren_i, rf_waddr_i, rf_wdata_i,
    input  whien_i, wloen_i, hi_i, lo_i,
    input  rd1_en_i, rd1_addr_i, rd2_en_i, rd2_addr_i,
    output rd1_data_o, rd2_data_o, hi_o, lo_o
  );
endinterface

// File: rtl/regfile_hilo.sv
// 31x32 GPR file (r0 hardwired to zero) plus HI/LO; writes land on the clock edge.
// Reads are combinational with same-cycle write-through bypass; no backpressure.
module regfile_hilo (
  input logic           clk,
  input logic           rst_n,
  regfile_hilo_if.slave rf
);

  logic [31:0] gpr_q [1:31];
  logic [31:0] gpr_d [1:31];
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      gpr_d[i] = gpr_q[i];
      if (rf.rf_wren_i && (rf.rf_waddr_i == 5'(i))) begin
        gpr_d[i] = rf.rf_wdata_i;
      end
    end
    hi_d = rf.whien_i ? rf.hi_i : hi_q;
    lo_d = rf.wloen_i ? rf.lo_i : lo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        gpr_q[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      gpr_q <= gpr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Outputs are forced to zero while reset is held, bypass included.
  function automatic logic [31:0] read_port(
    input logic        rstn,
    input logic        en,
    input logic [4:0]  addr,
    input logic        wren,
    input logic [4:0]  waddr,
    input logic [31:0] wdata,
    input logic [31:0] regs [1:31]
  );
    logic [31:0] val;
    val = '0;
    if (rstn && en && (addr != 5'd0)) begin
      if (wren && (waddr == addr)) begin
        val = wdata;
      end else begin
        for (int i = 1; i < 32; i++) begin
          if (addr == 5'(i)) begin
            val = regs[i];
          end
        end
      end
    end
    return val;
  endfunction

  assign rf.rd1_data_o = read_port(rst_n, rf.rd1_en_i, rf.rd1_addr_i,
                                   rf.rf_wren_i, rf.rf_waddr_i, rf.rf_wdata_i, gpr_q);
  assign rf.rd2_data_o = read_port(rst_n, rf.rd2_en_i, rf.rd2_addr_i,
                                   rf.rf_wren_i, rf.rf_waddr_i, rf.rf_wdata_i, gpr_q);

  assign rf.hi_o = !rst_n ? 32'h0 : (rf.whien_i ? rf.hi_i : hi_q);
  assign rf.lo_o = !rst_n ? 32'h0 : (rf.wloen_i ? rf.lo_i : lo_q);

endmodule

// File: tb/tb_regfile_hilo.sv
// Directed vector bench for regfile_hilo: bypass, r0, HI/LO, read enable and async reset.
module tb_regfile_hilo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_hilo_if rf_if ();

  regfile_hilo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf_if.slave)
  );

  typedef struct {
    logic        wren;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whien;
    logic        wloen;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        r1en;
    logic [4:0]  r1a;
    logic        r2en;
    logic [4:0]  r2a;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wren, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic whien, input logic wloen, input logic [31:0] hi,
                       input logic [31:0] lo, input logic r1en, input logic [4:0] r1a,
                       input logic r2en, input logic [4:0] r2a);
    rf_if.rf_wren_i  = wren;
    rf_if.rf_waddr_i = waddr;
    rf_if.rf_wdata_i = wdata;
    rf_if.whien_i    = whien;
    rf_if.wloen_i    = wloen;
    rf_if.hi_i       = hi;
    rf_if.lo_i       = lo;
    rf_if.rd1_en_i   = r1en;
    rf_if.rd1_addr_i = r1a;
    rf_if.rd2_en_i   = r2en;
    rf_if.rd2_addr_i = r2a;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rd1", rf_if.rd1_data_o, 32'h0);
    check("reset_hi", rf_if.hi_o, 32'h0);
    rst_n = 1'b1;

    //          wren  waddr  wdata         hien  loen  hi           lo           r1en r1a   r2en r2a   e1           e2           ehi          elo
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,       32'h0,       1'b1, 5'd5,  1'b1, 5'd6,  32'h0,       32'h0,       32'h0,       32'h0};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0,       32'h0,       1'b1, 5'd5,  1'b1, 5'd6,  32'hDEADBEEF, 32'h0,      32'h0,       32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,       32'h0,       1'b1, 5'd5,  1'b1, 5'd6,  32'hDEADBEEF, 32'h0,      32'h0,       32'h0};
    vecs[3]  = '{1'b1, 5'd7,  32'h12345678, 1'b0, 1'b0, 32'h0,       32'h0,       1'b1, 5'd7,  1'b1, 5'd7,  32'h12345678, 32'h12345678, 32'h0,    32'h0};
    vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,       32'h0,       1'b1, 5'd0,  1'b1, 5'd0,  32'h0,       32'h0,       32'h0,       32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,       32'h0,       1'b1, 5'd0,  1'b1, 5'd7,  32'h0,       32'h12345678, 32'h0,      32'h0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 32'hA,       32'hB,       1'b1, 5'd5,  1'b1, 5'd0,  32'hDEADBEEF, 32'h0,      32'hA,       32'h0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,       32'h0,       1'b1, 5'd0,  1'b1, 5'd0,  32'h0,       32'h0,       32'hA,       32'h0};
    vecs[8]  = '{1'b1, 5'd9,  32'h55,       1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 5'd9,  1'b1, 5'd9,  32'h0,       32'h55,      32'hA,       32'h0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 5'd9,  1'b0, 5'd9,  32'h0,       32'h0,       32'hA,       32'h0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,       32'h0,       1'b1, 5'd9,  1'b1, 5'd5,  32'h55,      32'hDEADBEEF, 32'hA,      32'h0};
    vecs[11] = '{1'b1, 5'd3,  32'h33,       1'b1, 1'b1, 32'h111,     32'h222,     1'b1, 5'd3,  1'b1, 5'd4,  32'h33,      32'h0,       32'h111,     32'h222};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,       32'h0,       1'b1, 5'd3,  1'b1, 5'd9,  32'h33,      32'h55,      32'h111,     32'h222};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 32'h999,     32'h333,     1'b1, 5'd7,  1'b1, 5'd0,  32'h12345678, 32'h0,      32'h111,     32'h333};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,       32'h0,       1'b1, 5'd7,  1'b1, 5'd3,  32'h12345678, 32'h33,     32'h111,     32'h333};
    vecs[15] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,       32'h0,       1'b1, 5'd31, 1'b1, 5'd30, 32'hCAFEF00D, 32'h0,      32'h111,     32'h333};
    vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,       32'h0,       1'b1, 5'd31, 1'b1, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF, 32'h111,  32'h333};

    for (int v = 0; v < NVEC; v++) begin
      @(negedge clk);
      drive(vecs[v].wren, vecs[v].waddr, vecs[v].wdata, vecs[v].whien, vecs[v].wloen,
            vecs[v].hi, vecs[v].lo, vecs[v].r1en, vecs[v].r1a, vecs[v].r2en, vecs[v].r2a);
      #2;
      check($sformatf("vec%0d_rd1", v), rf_if.rd1_data_o, vecs[v].e1);
      check($sformatf("vec%0d_rd2", v), rf_if.rd2_data_o, vecs[v].e2);
      check($sformatf("vec%0d_hi", v), rf_if.hi_o, vecs[v].ehi);
      check($sformatf("vec%0d_lo", v), rf_if.lo_o, vecs[v].elo);
    end

    // Fill r1..r31 with their index, then read every register back.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 32'(i), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    end
    @(negedge clk);
    idle();
    for (int i = 1; i < 32; i++) begin
      rf_if.rd1_en_i   = 1'b1;
      rf_if.rd1_addr_i = 5'(i);
      #1;
      check($sformatf("fill_r%0d", i), rf_if.rd1_data_o, 32'(i));
    end

    // Reset dropped between edges while a GPR and HI write are presented.
    @(negedge clk);
    drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 1'b0, 32'h77, 32'h0, 1'b1, 5'd3, 1'b1, 5'd31);
    #1;
    check("pre_rst_bypass_r3", rf_if.rd1_data_o, 32'hAAAA);
    rst_n = 1'b0;
    #1;
    check("rst_bypass_r3", rf_if.rd1_data_o, 32'h0);
    check("rst_r31", rf_if.rd2_data_o, 32'h0);
    check("rst_hi", rf_if.hi_o, 32'h0);
    check("rst_lo", rf_if.lo_o, 32'h0);
    @(posedge clk);
    @(negedge clk);
    // Release with a different write pending; the r3 write held through reset must be lost.
    drive(1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd3);
    rst_n = 1'b1;
    #1;
    check("rel_bypass_r4", rf_if.rd1_data_o, 32'h44);
    check("rel_r3", rf_if.rd2_data_o, 32'h0);
    @(negedge clk);
    idle();
    rf_if.rd1_en_i = 1'b1;
    rf_if.rd1_addr_i = 5'd4;
    rf_if.rd2_en_i = 1'b1;
    rf_if.rd2_addr_i = 5'd3;
    #1;
    check("post_r4", rf_if.rd1_data_o, 32'h44);
    check("post_r3", rf_if.rd2_data_o, 32'h0);
    check("post_hi", rf_if.hi_o, 32'h0);
    for (int i = 5; i < 32; i += 13) begin
      rf_if.rd1_addr_i = 5'(i);
      #1;
      check($sformatf("post_r%0d", i), rf_if.rd1_data_o, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
